// File: rtl/idma_desc64_chain_walker.sv
// Descriptor chain walker: fetches 4x64-bit descriptors from memory, hands
// each one downstream and follows the next pointer until the end marker.
module idma_desc64_chain_walker #(
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] EndMarker = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic                 abort_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i,
    output logic [255:0]         desc_o,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic                 busy_o,
    output logic                 chain_done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HANDOFF = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [2:0]           issued_q, issued_d;
    logic [2:0]           received_q, received_d;
    logic                 chain_done_q, chain_done_d;
    logic                 store_word;
    logic [63:0]          word_q [4];
    logic [AddrWidth-1:0] next_ptr;

    // word1 of the descriptor carries the next pointer
    assign next_ptr     = word_q[1][AddrWidth-1:0];
    // request address walks the four words of the current descriptor; wraps modulo 2^AddrWidth
    assign mem_addr_o   = base_q + AddrWidth'({issued_q, 3'b000});
    assign desc_o       = {word_q[3], word_q[2], word_q[1], word_q[0]};
    assign busy_o       = (state_q != IDLE);
    assign chain_done_o = chain_done_q;

    // next-state, counter and handshake logic
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issued_d      = issued_q;
        received_d    = received_q;
        chain_done_d  = 1'b0;
        store_word    = 1'b0;
        start_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        desc_valid_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                // abort has priority over a coincident doorbell
                if (start_valid_i && !abort_i) begin
                    base_d     = {start_addr_i[AddrWidth-1:3], 3'b000};
                    issued_d   = 3'd0;
                    received_d = 3'd0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // abort suppresses the request in the same cycle so nothing new is issued
                mem_req_o = (issued_q < 3'd4) && !abort_i;
                if (mem_req_o && mem_gnt_i) begin
                    issued_d = issued_q + 3'd1;
                end
                if (mem_rvalid_i && (received_q < 3'd4)) begin
                    store_word = 1'b1;
                    received_d = received_q + 3'd1;
                end
                if (abort_i) begin
                    state_d = (received_d < issued_d) ? DRAIN : IDLE;
                end else if (received_d == 3'd4) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    if (next_ptr == EndMarker) begin
                        chain_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        base_d     = {next_ptr[AddrWidth-1:3], 3'b000};
                        issued_d   = 3'd0;
                        received_d = 3'd0;
                        state_d    = FETCH;
                    end
                end else if (abort_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // responses of an abandoned descriptor are counted but discarded
                if (mem_rvalid_i) begin
                    received_d = received_q + 3'd1;
                end
                if (received_d == issued_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and descriptor word storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issued_q     <= 3'd0;
            received_q   <= 3'd0;
            chain_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= 64'd0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            chain_done_q <= chain_done_d;
            if (store_word) begin
                word_q[received_q[1:0]] <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_idma_desc64_chain_walker.sv
// Bench for idma_desc64_chain_walker: memory responder, descriptor sink and a
// chain-walking reference model built from the descriptor layout rules.
module tb_idma_desc64_chain_walker;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [63:0]  start_addr_i;
    logic         start_valid_i;
    logic         start_ready_o;
    logic         abort_i;
    logic         mem_req_o;
    logic [63:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;
    logic [255:0] desc_o;
    logic         desc_valid_o;
    logic         desc_ready_i;
    logic         busy_o;
    logic         chain_done_o;

    idma_desc64_chain_walker dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_addr_i  (start_addr_i),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .abort_i       (abort_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .desc_o        (desc_o),
        .desc_valid_o  (desc_valid_o),
        .desc_ready_i  (desc_ready_i),
        .busy_o        (busy_o),
        .chain_done_o  (chain_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    int           n_total = 0;
    int           n_bad   = 0;
    int           cyc     = 0;
    logic [63:0]  mem [logic [63:0]];
    pend_t        pend [$];
    logic [255:0] hs_log [$];
    logic [255:0] exp_desc [$];
    logic [63:0]  req_log [$];
    logic [63:0]  exp_addr [$];

    // responder / sink knobs
    int gnt_pct = 100, lat_lo = 0, lat_hi = 0, ready_pct = 100, ready_stall = 0;
    int stall_idx = -1, stall_n = 0, stall_left = 0, stall_seen = 0;
    int gnt_count = 0, rv_count = 0, done_cnt = 0, last_due = 0, vcnt = 0;
    bit stall_done = 0, prev_wait = 0;
    logic [63:0] prev_addr = '0, held_addr = '0;
    bit m_prev_valid = 0, m_prev_hs = 0;
    logic [255:0] m_prev_desc = '0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0BAD_0BAD_0BAD_0BAD;
    endfunction

    task automatic put_desc(input logic [63:0] b, input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3);
        mem[b] = w0; mem[b + 64'd8] = w1; mem[b + 64'd16] = w2; mem[b + 64'd24] = w3;
    endtask

    // reference: walk the chain in memory, 4 reads per descriptor, stop at all-ones next
    task automatic model_walk(input logic [63:0] start);
        logic [63:0] b, a;
        logic [63:0] w [4];
        exp_desc.delete(); exp_addr.delete();
        b = {start[63:3], 3'b000};
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                a = b + 64'(8 * i);
                exp_addr.push_back(a);
                w[i] = rd(a);
            end
            exp_desc.push_back({w[3], w[2], w[1], w[0]});
            if (w[1] == ALL1) break;
            b = {w[1][63:3], 3'b000};
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder and descriptor sink, driven just after the falling edge
    always @(negedge clk) begin
        bit g;
        int d;
        #1;
        if (rst_i) begin
            pend.delete();
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; desc_ready_i = 0;
            vcnt = 0; stall_left = 0; prev_wait = 0; last_due = 0;
        end else begin
            if (mem_req_o && prev_wait) check_val("addr_hold", mem_addr_o, prev_addr);
            if (mem_req_o && stall_left > 0) begin
                g = 0; stall_left--; stall_seen++;
            end else if (mem_req_o && !stall_done && gnt_count == stall_idx) begin
                stall_done = 1; stall_left = stall_n - 1; stall_seen++;
                held_addr = mem_addr_o; g = 0;
            end else begin
                g = ($urandom_range(99, 0) < gnt_pct);
            end
            mem_gnt_i = g;
            prev_wait = mem_req_o && !g;
            prev_addr = mem_addr_o;
            if (mem_req_o && g) begin
                d = cyc + $urandom_range(lat_hi, lat_lo);
                if (d < last_due) d = last_due;
                last_due = d;
                pend.push_back('{addr: mem_addr_o, due: d});
                req_log.push_back(mem_addr_o);
                gnt_count++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid_i = 1;
                mem_rdata_i  = rd(pend[0].addr);
                void'(pend.pop_front());
                rv_count++;
            end else begin
                mem_rvalid_i = 0;
                mem_rdata_i  = 64'($urandom);
            end
            if (desc_valid_o) begin
                desc_ready_i = (vcnt >= ready_stall) && ($urandom_range(99, 0) < ready_pct);
                vcnt++;
            end else begin
                desc_ready_i = 0;
                vcnt = 0;
            end
        end
    end

    // output monitor: descriptor stability, handoff log, chain_done pulses
    always @(negedge clk) begin
        #3;
        if (rst_i) begin
            m_prev_valid = 0; m_prev_hs = 0;
        end else begin
            if (desc_valid_o && m_prev_valid && !m_prev_hs) check_val("desc_hold", desc_o, m_prev_desc);
            if (desc_valid_o && desc_ready_i) hs_log.push_back(desc_o);
            if (chain_done_o) done_cnt++;
            m_prev_valid = desc_valid_o;
            m_prev_hs    = desc_valid_o && desc_ready_i;
            m_prev_desc  = desc_o;
        end
    end

    task automatic clear_logs();
        hs_log.delete(); req_log.delete();
        done_cnt = 0; gnt_count = 0; rv_count = 0;
        stall_done = 0; stall_seen = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_srdy"}, start_ready_o, 1'b1);
        check_val({tag, "_req"},  mem_req_o, 1'b0);
        check_val({tag, "_dvld"}, desc_valid_o, 1'b0);
        check_val({tag, "_busy"}, busy_o, 1'b0);
        check_val({tag, "_done"}, chain_done_o, 1'b0);
        check_val({tag, "_desc"}, desc_o, 256'd0);
        check_val({tag, "_addr"}, mem_addr_o, 64'd0);
    endtask

    task automatic start_chain(input logic [63:0] a);
        clear_logs();
        @(negedge clk);
        start_addr_i = a; start_valid_i = 1;
        @(negedge clk);
        start_valid_i = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 3000) begin
            @(negedge clk); n++;
        end
        check_val({tag, "_tmo"}, busy_o, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_chain(input logic [63:0] a, input string tag);
        model_walk(a);
        start_chain(a);
        wait_idle(tag);
        check_val({tag, "_ndesc"}, hs_log.size(), exp_desc.size());
        for (int i = 0; i < exp_desc.size(); i++)
            check_val({tag, "_desc"}, (i < hs_log.size()) ? hs_log[i] : 256'd0, exp_desc[i]);
        check_val({tag, "_nrd"}, req_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++)
            check_val({tag, "_rdaddr"}, (i < req_log.size()) ? req_log[i] : 64'd1, exp_addr[i]);
        check_val({tag, "_chdone"}, done_cnt, 1);
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (gnt_count < n && k < 200) begin
            @(negedge clk); k++;
        end
        check_val("grant_tmo", gnt_count >= n, 1'b1);
    endtask

    initial begin : main
        int          len, n;
        logic [63:0] bases [4];
        logic [63:0] nxt;
        rst_i = 1; start_addr_i = '0; start_valid_i = 0; abort_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; desc_ready_i = 0;
        repeat (3) @(negedge clk);
        rst_i = 0;
        check_reset_outs("rst");

        // single descriptor
        put_desc(64'h1000, 64'h0000_0003_0000_0100, ALL1, 64'hAAAA_0000_0000_1111, 64'hBBBB_0000_0000_2222);
        run_chain(64'h1000, "single");

        // three-descriptor chain with stalled sink
        put_desc(64'h1000, 64'h11, 64'h2000, 64'h1A, 64'h1B);
        put_desc(64'h2000, 64'h22, 64'h3000, 64'h2A, 64'h2B);
        put_desc(64'h3000, 64'h33, ALL1, 64'h3A, 64'h3B);
        ready_stall = 5;
        run_chain(64'h1000, "chain3");
        ready_stall = 0;

        // grant withheld on second request, delayed read data
        put_desc(64'h1000, 64'hF00D_0000_0000_0040, ALL1, 64'hCAFE_0000, 64'hBEEF_0000);
        stall_idx = 1; stall_n = 3; lat_lo = 2; lat_hi = 2;
        run_chain(64'h1000, "gstall");
        check_val("gstall_held", held_addr, 64'h1008);
        check_val("gstall_cycles", stall_seen, 3);
        stall_idx = -1; lat_lo = 0; lat_hi = 0;

        // unaligned start address
        run_chain(64'h1005, "unal");
        check_val("unal_first", (req_log.size() > 0) ? req_log[0] : 64'd1, 64'h1000);

        // next pointer at the top of the address space wraps
        put_desc(64'h5000, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5A, 64'h5B);
        put_desc(64'hFFFF_FFFF_FFFF_FFF8, 64'h66, 64'h0, 64'h6A, 64'h6B);
        mem[64'h0] = ALL1;
        run_chain(64'h5000, "wrap");
        check_val("wrap_w1", (req_log.size() > 5) ? req_log[5] : 64'd1, 64'h0);

        // abort with two reads in flight
        lat_lo = 10; lat_hi = 10;
        start_chain(64'h1000);
        wait_grants(2);
        abort_i = 1;
        @(negedge clk);
        abort_i = 0;
        check_val("abort_busy", busy_o, 1'b1);
        check_val("abort_noreq", mem_req_o, 1'b0);
        wait_idle("abort");
        check_val("abort_nreq", req_log.size(), 2);
        check_val("abort_rv", rv_count, 2);
        check_val("abort_pend", pend.size(), 0);
        check_val("abort_hs", hs_log.size(), 0);
        check_val("abort_done", done_cnt, 0);

        // reset mid-fetch, then a clean chain
        start_chain(64'h1000);
        wait_grants(2);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        check_reset_outs("rstf");
        lat_lo = 0; lat_hi = 1;
        run_chain(64'h1000, "recov");

        // reset while holding a descriptor
        ready_pct = 0;
        start_chain(64'h1000);
        n = 0;
        while (!desc_valid_o && n < 100) begin @(negedge clk); n++; end
        check_val("rsth_vld", desc_valid_o, 1'b1);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        check_reset_outs("rsth");

        // abort while holding a descriptor with the sink not ready
        start_chain(64'h1000);
        n = 0;
        while (!desc_valid_o && n < 100) begin @(negedge clk); n++; end
        abort_i = 1;
        @(negedge clk);
        abort_i = 0;
        check_val("aborth_vld", desc_valid_o, 1'b0);
        check_val("aborth_busy", busy_o, 1'b0);
        check_val("aborth_hs", hs_log.size(), 0);
        ready_pct = 100;

        // randomized chains
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(4, 1);
            for (int k = 0; k < 4; k++)
                bases[k] = {32'($urandom), 20'($urandom), 12'h000} + 64'(k * 256);
            for (int k = 0; k < len; k++) begin
                nxt = (k == len - 1) ? ALL1 : (bases[k + 1] | 64'($urandom_range(7, 0)));
                put_desc(bases[k], {$urandom, $urandom}, nxt, {$urandom, $urandom}, {$urandom, $urandom});
            end
            gnt_pct = $urandom_range(100, 30);
            lat_lo = 0; lat_hi = $urandom_range(3, 0);
            ready_pct = $urandom_range(100, 30);
            ready_stall = $urandom_range(2, 0);
            run_chain(bases[0] | 64'($urandom_range(7, 0)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
